pillow_drop_controller: RTL and testbench

- Sequences the falling-pillow datapath of the dodge game.
- Spawns a pillow at a pseudo-random column and advances it down the screen once per frame tick.
- Scores each pillow that passes the bottom and raises fall speed as dodges accumulate.
- Freezes play when the collision detector raises fail; ENTER starts or restarts the game.
- Its pillow coordinate outputs drive the collision detector and the pillow sprite renderer.

---
 rtl/pillow_drop_controller_if.sv | 24 ++
 rtl/pillow_drop_controller.sv | 125 ++++++++++++
 tb/tb_pillow_drop_controller.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pillow_drop_controller_if.sv
// pillow_drop_controller_if: game inputs and pillow/score outputs of the pillow drop controller
interface pillow_drop_controller_if;
  logic frame_tick;
  logic [7:0] scan_code;
  logic fail;
  logic [10:0] pillow_column_begin;
  logic [10:0] pillow_column_end;
  logic [10:0] pillow_row_begin;
  logic [10:0] pillow_row_end;
  logic [15:0] score;
  logic [3:0] speed;
  logic [2:0] state;
  logic game_over;
  modport master (
    input frame_tick, scan_code, fail,
    output pillow_column_begin, pillow_column_end, pillow_row_begin, pillow_row_end,
    output score, speed, state, game_over
  );
  modport slave (
    output frame_tick, scan_code, fail,
    input pillow_column_begin, pillow_column_end, pillow_row_begin, pillow_row_end,
    input score, speed, state, game_over
  );
endinterface

// File: rtl/pillow_drop_controller.sv
// pillow_drop_controller: spawns, drops and scores pillows; define PILLOW_PAUSE_EN to add a P-key pause state
module pillow_drop_controller #(
  parameter int SCREEN_W = 800,
  parameter int SCREEN_H = 600,
  parameter int PILLOW_W = 40,
  parameter int PILLOW_H = 40,
  parameter int SPEED_INIT = 2,
  parameter int SPEED_MAX = 12,
  parameter int SPEED_STEP = 5,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic clk,
  input logic reset,
  pillow_drop_controller_if.master bus
);
  typedef enum logic [2:0] {IDLE = 3'd0, RESPAWN = 3'd1, DROP = 3'd2, OVER = 3'd3, PAUSE = 3'd4} state_t;
  localparam logic [10:0] COL_SPAN = 11'(SCREEN_W - PILLOW_W);
  localparam logic [10:0] ROW_LAST = 11'(SCREEN_H - PILLOW_H);
  localparam logic [10:0] W_M1 = 11'(PILLOW_W - 1);
  localparam logic [10:0] H_M1 = 11'(PILLOW_H - 1);
  localparam logic [7:0] KEY_ENTER = 8'h5A;
  state_t state_q, state_d;
  logic [10:0] col_q, col_d, row_q, row_d, col_end_q, row_end_q;
  logic [15:0] score_q, score_d;
  logic [3:0] speed_q, speed_d;
  logic [7:0] dodge_q, dodge_d;
  logic over_q, over_d;
  logic [15:0] lfsr_q;
  logic [7:0] last_q;
  logic enter_ev, pause_ev, exited, step_hit;
  logic [10:0] raw_col, spawn_col, row_next;
  logic [7:0] dodge_inc;
  logic [3:0] speed_up;
  logic [15:0] score_inc;
  assign enter_ev = (bus.scan_code != last_q) && (bus.scan_code == KEY_ENTER);
`ifdef PILLOW_PAUSE_EN
  assign pause_ev = (bus.scan_code != last_q) && (bus.scan_code == 8'h4D);
`else
  assign pause_ev = 1'b0;
`endif
  // One conditional subtract folds the 10-bit draw into the visible span (span >= 512)
  assign raw_col = {1'b0, lfsr_q[9:0]};
  assign spawn_col = raw_col >= COL_SPAN ? raw_col - COL_SPAN : raw_col;
  assign row_next = row_q + 11'(speed_q);
  assign exited = row_next > ROW_LAST;
  assign dodge_inc = dodge_q + 8'd1;
  assign step_hit = dodge_inc == 8'(SPEED_STEP);
  assign speed_up = speed_q >= 4'(SPEED_MAX) ? speed_q : speed_q + 4'd1;
  assign score_inc = &score_q ? score_q : score_q + 16'd1;
  always_comb begin
    state_d = state_q;
    col_d = col_q;
    row_d = row_q;
    score_d = score_q;
    speed_d = speed_q;
    dodge_d = dodge_q;
    over_d = over_q;
    case (state_q)
      IDLE, OVER: if (enter_ev) begin
        score_d = 16'd0;
        dodge_d = 8'd0;
        speed_d = 4'(SPEED_INIT);
        over_d = 1'b0;
        state_d = RESPAWN;
      end
      RESPAWN: begin
        col_d = spawn_col;
        row_d = 11'd0;
        state_d = DROP;
      end
      DROP: if (bus.fail) begin
        over_d = 1'b1;
        state_d = OVER;
      end else if (pause_ev) begin
        state_d = PAUSE;
      end else if (bus.frame_tick) begin
        if (exited) begin
          score_d = score_inc;
          dodge_d = step_hit ? 8'd0 : dodge_inc;
          speed_d = step_hit ? speed_up : speed_q;
          state_d = RESPAWN;
        end else begin
          row_d = row_next;
        end
      end
      PAUSE: state_d = pause_ev ? DROP : PAUSE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      col_q <= 11'd0;
      row_q <= 11'd0;
      col_end_q <= W_M1;
      row_end_q <= H_M1;
      score_q <= 16'd0;
      speed_q <= 4'(SPEED_INIT);
      dodge_q <= 8'd0;
      over_q <= 1'b0;
      lfsr_q <= LFSR_SEED;
      last_q <= 8'd0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      col_end_q <= col_d + W_M1;
      row_end_q <= row_d + H_M1;
      score_q <= score_d;
      speed_q <= speed_d;
      dodge_q <= dodge_d;
      over_q <= over_d;
      lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
      last_q <= bus.scan_code;
    end
  end
  assign bus.pillow_column_begin = col_q;
  assign bus.pillow_column_end = col_end_q;
  assign bus.pillow_row_begin = row_q;
  assign bus.pillow_row_end = row_end_q;
  assign bus.score = score_q;
  assign bus.speed = speed_q;
  assign bus.state = state_q;
  assign bus.game_over = over_q;
endmodule

// File: tb/tb_pillow_drop_controller.sv
// tb_pillow_drop_controller: directed game scenarios with a spawn-column scoreboard
module tb_pillow_drop_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  pillow_drop_controller_if bus();
  pillow_drop_controller dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int exp_state, exp_row, exp_score, exp_speed, exp_dodge, exits;
  logic [15:0] m_lfsr;
  logic [2:0] prev_state = 3'd0;
  logic [10:0] col_q[$];
  function automatic logic [10:0] spawn(input logic [15:0] l);
    int r;
    r = int'(l[9:0]);
    if (r >= 760) r = r - 760;
    return 11'(r);
  endfunction
  always @(posedge clk) m_lfsr <= reset ? 16'hACE1 : {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  // Expected column is queued while RESPAWN is visible and checked on entry to DROP
  always @(negedge clk) begin
    if (!reset && bus.state == 3'd1) col_q.push_back(spawn(m_lfsr));
    if (!reset && bus.state == 3'd2 && prev_state == 3'd1) begin
      checks++;
      if (col_q.size() == 0) begin
        errors++;
        $display("FAIL spawn_col: entered DROP with no queued column, column=%0d", bus.pillow_column_begin);
      end else begin
        logic [10:0] e;
        e = col_q.pop_front();
        if (bus.pillow_column_begin !== e || bus.pillow_column_end !== e + 11'd39 || bus.pillow_row_begin !== 11'd0) begin
          errors++;
          $display("FAIL spawn_col: col=%0d end=%0d row=%0d, expected col=%0d end=%0d row=0",
                   bus.pillow_column_begin, bus.pillow_column_end, bus.pillow_row_begin, e, e + 11'd39);
        end
      end
    end
    prev_state <= bus.state;
  end
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask
  task automatic model_cycle(input logic tk);
    bus.frame_tick = tk;
    if (exp_state == 2 && tk) begin
      if (exp_row + exp_speed > 560) begin
        exp_score++;
        exp_dodge++;
        if (exp_dodge == 5) begin
          exp_dodge = 0;
          if (exp_speed < 12) exp_speed++;
        end
        exp_state = 1;
        exits++;
      end else exp_row += exp_speed;
    end else if (exp_state == 1) begin
      exp_state = 2;
      exp_row = 0;
    end
    cycle();
    bus.frame_tick = 1'b0;
    checks++;
    if (bus.state !== 3'(exp_state) || bus.pillow_row_begin !== 11'(exp_row) || bus.pillow_row_end !== 11'(exp_row + 39)
        || bus.score !== 16'(exp_score) || bus.speed !== 4'(exp_speed)) begin
      errors++;
      $display("FAIL model_cycle: state=%0d row=%0d row_end=%0d score=%0d speed=%0d, expected %0d %0d %0d %0d %0d",
               bus.state, bus.pillow_row_begin, bus.pillow_row_end, bus.score, bus.speed,
               exp_state, exp_row, exp_row + 39, exp_score, exp_speed);
    end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    cycle();
    cycle();
    checks++;
    if (bus.state !== 3'd0 || bus.pillow_column_begin !== 11'd0 || bus.pillow_column_end !== 11'd39
        || bus.pillow_row_begin !== 11'd0 || bus.pillow_row_end !== 11'd39 || bus.score !== 16'd0
        || bus.speed !== 4'd2 || bus.game_over !== 1'b0 || dut.lfsr_q !== 16'hACE1) begin
      errors++;
      $display("FAIL reset: state=%0d col=%0d/%0d row=%0d/%0d score=%0d speed=%0d over=%b lfsr=%h, expected 0 0/39 0/39 0 2 0 ace1",
               bus.state, bus.pillow_column_begin, bus.pillow_column_end, bus.pillow_row_begin,
               bus.pillow_row_end, bus.score, bus.speed, bus.game_over, dut.lfsr_q);
    end
    reset = 1'b0;
    cycle();
    checks++;
    if (bus.state !== 3'd0) begin
      errors++;
      $display("FAIL idle_hold: state=%0d, expected 0", bus.state);
    end
  endtask
  task automatic test_start();
    bus.scan_code = 8'h5A;
    cycle();
    checks++;
    if (bus.state !== 3'd1) begin
      errors++;
      $display("FAIL start_respawn: state=%0d, expected 1", bus.state);
    end
    cycle();
    checks++;
    if (bus.state !== 3'd2 || bus.pillow_row_begin !== 11'd0 || bus.pillow_column_begin >= 11'd760
        || bus.score !== 16'd0 || bus.speed !== 4'd2) begin
      errors++;
      $display("FAIL start_drop: state=%0d row=%0d col=%0d score=%0d speed=%0d, expected 2 0 <760 0 2",
               bus.state, bus.pillow_row_begin, bus.pillow_column_begin, bus.score, bus.speed);
    end
    repeat (8) cycle();
    checks++;
    if (bus.state !== 3'd2) begin
      errors++;
      $display("FAIL start_hold: state=%0d, expected 2", bus.state);
    end
    exp_state = 2; exp_row = 0; exp_score = 0; exp_speed = 2; exp_dodge = 0; exits = 0;
  endtask
  task automatic test_drop();
    bus.scan_code = 8'h00;
    model_cycle(1'b0);
    bus.scan_code = 8'h5A;
    repeat (50) model_cycle(1'b1);
    checks++;
    if (bus.pillow_row_begin !== 11'd100 || bus.pillow_row_end !== 11'd139 || bus.state !== 3'd2) begin
      errors++;
      $display("FAIL drop_50: row=%0d end=%0d state=%0d, expected 100 139 2",
               bus.pillow_row_begin, bus.pillow_row_end, bus.state);
    end
  endtask
  task automatic test_exit();
    for (int i = 0; i < 1000 && exits < 1; i++) model_cycle(1'b1);
    checks++;
    if (bus.score !== 16'd1 || bus.state !== 3'd1) begin
      errors++;
      $display("FAIL first_exit: score=%0d state=%0d, expected 1 1", bus.score, bus.state);
    end
    for (int i = 0; i < 3000 && exits < 5; i++) model_cycle(1'b1);
    model_cycle(1'b1);
    checks++;
    if (bus.speed !== 4'd3 || bus.score !== 16'd5 || bus.state !== 3'd2) begin
      errors++;
      $display("FAIL speed_step: speed=%0d score=%0d state=%0d, expected 3 5 2", bus.speed, bus.score, bus.state);
    end
  endtask
  task automatic test_fail_over();
    for (int i = 0; i < 400 && exp_row < 480; i++) model_cycle(1'b1);
    checks++;
    if (bus.pillow_row_begin !== 11'd480) begin
      errors++;
      $display("FAIL pre_fail_row: row=%0d, expected 480", bus.pillow_row_begin);
    end
    bus.fail = 1'b1;
    bus.frame_tick = 1'b1;
    repeat (3) cycle();
    checks++;
    if (bus.state !== 3'd3 || bus.game_over !== 1'b1 || bus.pillow_row_begin !== 11'd480
        || bus.score !== 16'd5 || bus.speed !== 4'd3) begin
      errors++;
      $display("FAIL fail_over: state=%0d over=%b row=%0d score=%0d speed=%0d, expected 3 1 480 5 3",
               bus.state, bus.game_over, bus.pillow_row_begin, bus.score, bus.speed);
    end
    bus.fail = 1'b0;
    bus.frame_tick = 1'b0;
    bus.scan_code = 8'h00;
    cycle();
    bus.scan_code = 8'h5A;
    cycle();
    checks++;
    if (bus.state !== 3'd1 || bus.score !== 16'd0 || bus.speed !== 4'd2 || bus.game_over !== 1'b0) begin
      errors++;
      $display("FAIL restart: state=%0d score=%0d speed=%0d over=%b, expected 1 0 2 0",
               bus.state, bus.score, bus.speed, bus.game_over);
    end
    exp_state = 1; exp_row = 480; exp_score = 0; exp_speed = 2; exp_dodge = 0;
    model_cycle(1'b0);
  endtask
  task automatic test_reset_mid();
    repeat (5) model_cycle(1'b1);
    bus.scan_code = 8'h00;
    reset = 1'b1;
    cycle();
    checks++;
    if (bus.state !== 3'd0 || bus.pillow_row_end !== 11'd39 || bus.pillow_column_end !== 11'd39
        || bus.score !== 16'd0 || bus.speed !== 4'd2 || dut.lfsr_q !== 16'hACE1) begin
      errors++;
      $display("FAIL reset_mid: state=%0d row_end=%0d col_end=%0d score=%0d speed=%0d lfsr=%h, expected 0 39 39 0 2 ace1",
               bus.state, bus.pillow_row_end, bus.pillow_column_end, bus.score, bus.speed, dut.lfsr_q);
    end
    reset = 1'b0;
    cycle();
  endtask
  task automatic test_pause();
    logic [2:0] st_p, st_f, st_r;
    logic [10:0] row_t;
`ifdef PILLOW_PAUSE_EN
    st_p = 3'd4; st_f = 3'd4; st_r = 3'd2; row_t = 11'd200;
`else
    st_p = 3'd2; st_f = 3'd3; st_r = 3'd3; row_t = 11'd260;
`endif
    bus.scan_code = 8'h5A;
    exp_state = 0;
    cycle();
    cycle();
    exp_state = 2; exp_row = 0; exp_score = 0; exp_speed = 2; exp_dodge = 0;
    repeat (100) model_cycle(1'b1);
    bus.scan_code = 8'h4D;
    cycle();
    checks++;
    if (bus.state !== st_p) begin
      errors++;
      $display("FAIL pause_enter: state=%0d, expected %0d", bus.state, st_p);
    end
    bus.frame_tick = 1'b1;
    repeat (30) cycle();
    bus.frame_tick = 1'b0;
    checks++;
    if (bus.pillow_row_begin !== row_t) begin
      errors++;
      $display("FAIL pause_ticks: row=%0d, expected %0d", bus.pillow_row_begin, row_t);
    end
    bus.fail = 1'b1;
    cycle();
    bus.fail = 1'b0;
    checks++;
    if (bus.state !== st_f) begin
      errors++;
      $display("FAIL pause_fail: state=%0d, expected %0d", bus.state, st_f);
    end
    bus.scan_code = 8'h00;
    cycle();
    bus.scan_code = 8'h4D;
    cycle();
    checks++;
    if (bus.state !== st_r || bus.pillow_row_begin !== row_t) begin
      errors++;
      $display("FAIL pause_resume: state=%0d row=%0d, expected %0d %0d", bus.state, bus.pillow_row_begin, st_r, row_t);
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end
  initial begin
    bus.frame_tick = 1'b0;
    bus.scan_code = 8'h00;
    bus.fail = 1'b0;
    test_reset();
    test_start();
    test_drop();
    test_exit();
    test_fail_over();
    test_reset_mid();
    test_pause();
    cycle();
    checks++;
    if (col_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d columns left, expected 0", col_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
